// File: rtl/jtag_dr_select.sv
// jtag_dr_select: routes TAP DR strobes to the channel chosen by the IR and muxes its serial data back to TDO.
// Optional DR_SHIFT_COUNT_EN adds a per-scan shift-length check reported on len_err.
module jtag_dr_select #(
  parameter int N_CH = 4,
  parameter int IR_W = 4,
  parameter logic [N_CH*IR_W-1:0] OPC = {4'h2, 4'h1, 4'h0, 4'hF},
  parameter logic [N_CH*16-1:0] LEN = {16'd32, 16'd32, 16'd32, 16'd1},
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IR_W-1:0] ir_value,
  input  logic            update_ir,
  input  logic            capture_dr,
  input  logic            shift_dr,
  input  logic            update_dr,
  input  logic [N_CH-1:0] s_data_in,
  output logic            s_data_out,
  output logic [N_CH-1:0] capture_dr_out,
  output logic [N_CH-1:0] shift_dr_out,
  output logic [N_CH-1:0] update_dr_out,
  output logic [CH_W-1:0] sel_out,
  output logic            busy,
  output logic            ir_drop,
  output logic            len_err
);
  typedef enum logic [1:0] {IDLE, CAP, SHIFT, UPD} state_t;
  state_t state, next;
  logic [CH_W-1:0] sel, match;
  always_comb begin
    match = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (ir_value == OPC[i*IR_W +: IR_W]) match = CH_W'(i);
  end
  always_comb begin
    next = IDLE;
    if (capture_dr) next = CAP;
    else if (state == CAP) next = shift_dr ? SHIFT : IDLE;
    else if (state == SHIFT) next = update_dr ? UPD : shift_dr ? SHIFT : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      ir_drop    <= 1'b0;
      s_data_out <= 1'b0;
    end else begin
      state   <= next;
      ir_drop <= update_ir && busy;
      if (update_ir && !busy) sel <= match;
      if (shift_dr) s_data_out <= s_data_in[sel];
    end
  assign busy    = state != IDLE;
  assign sel_out = sel;
  // Strobes are masked during reset so an aborted scan cannot leak an update pulse.
  assign capture_dr_out = rst ? '0 : N_CH'(capture_dr) << sel;
  assign shift_dr_out   = rst ? '0 : N_CH'(shift_dr) << sel;
  assign update_dr_out  = rst ? '0 : N_CH'(update_dr) << sel;
`ifdef DR_SHIFT_COUNT_EN
  logic [15:0] cnt;
  // The first Shift-DR cycle arrives while the FSM is still in CAP, so it seeds the count.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt     <= '0;
      len_err <= 1'b0;
    end else begin
      cnt     <= state == CAP ? 16'(shift_dr) :
                 (state == SHIFT && shift_dr && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
      len_err <= capture_dr ? 1'b0 :
                 (state == SHIFT && next == UPD && cnt != LEN[sel*16 +: 16]) ? 1'b1 : len_err;
    end
`else
  assign len_err = 1'b0;
`endif
endmodule

// File: tb/tb_jtag_dr_select.sv
// tb_jtag_dr_select: table-driven vectors with a scoreboard queue, plus shift-length and mid-scan reset sequences.
module tb_jtag_dr_select;
  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] ir_value = '0, s_data_in = '0;
  logic       update_ir = 1'b0, capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
  logic       s_data_out, busy, ir_drop, len_err;
  logic [3:0] capture_dr_out, shift_dr_out, update_dr_out;
  logic [1:0] sel_out;
  always #5 clk = ~clk;
  jtag_dr_select dut (
    .clk(clk), .rst(rst), .ir_value(ir_value), .update_ir(update_ir),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .s_data_in(s_data_in), .s_data_out(s_data_out),
    .capture_dr_out(capture_dr_out), .shift_dr_out(shift_dr_out), .update_dr_out(update_dr_out),
    .sel_out(sel_out), .busy(busy), .ir_drop(ir_drop), .len_err(len_err)
  );
`ifdef DR_SHIFT_COUNT_EN
  localparam logic EXP_LE = 1'b1;
`else
  localparam logic EXP_LE = 1'b0;
`endif
  typedef struct {
    logic ui; logic [3:0] ir; logic c, s, u; logic [3:0] sdi;
    logic [1:0] sel; logic busy, drop, sdo, cl, le;
  } vec_t;
  vec_t q[$];
  vec_t tbl[30];
  vec_t e_m;
  int total = 0, bad = 0;
  logic [1:0] cur_sel = '0;
  logic [3:0] oh;
  function automatic vec_t v(logic ui, logic [3:0] ir, logic c, logic s, logic u, logic [3:0] sdi,
                             logic [1:0] sel, logic b, logic d, logic sdo, logic cl = 0, logic le = 0);
    vec_t t;
    t.ui = ui; t.ir = ir; t.c = c; t.s = s; t.u = u; t.sdi = sdi;
    t.sel = sel; t.busy = b; t.drop = d; t.sdo = sdo; t.cl = cl; t.le = le;
    return t;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step(input vec_t t);
    @(negedge clk);
    ir_value = t.ir; update_ir = t.ui; capture_dr = t.c; shift_dr = t.s; update_dr = t.u; s_data_in = t.sdi;
    #1;
    oh = 4'b0001 << cur_sel;
    chk("capture_dr_out", capture_dr_out, t.c ? oh : 4'b0);
    chk("shift_dr_out", shift_dr_out, t.s ? oh : 4'b0);
    chk("update_dr_out", update_dr_out, t.u ? oh : 4'b0);
    q.push_back(t);
    cur_sel = t.sel;
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      e_m = q.pop_front();
      chk("sel_out", sel_out, e_m.sel);
      chk("busy", busy, e_m.busy);
      chk("ir_drop", ir_drop, e_m.drop);
      chk("s_data_out", s_data_out, e_m.sdo);
      if (e_m.cl) chk("len_err", len_err, e_m.le);
    end
  end
  initial begin
    //            ui ir   c  s  u  sdi  | sel busy drop sdo
    tbl[0]  = v(0, 4'h0, 1, 0, 0, 4'h0, 0, 1, 0, 0);
    tbl[1]  = v(0, 4'h0, 0, 1, 0, 4'h1, 0, 1, 0, 1);
    tbl[2]  = v(0, 4'h0, 0, 1, 0, 4'hE, 0, 1, 0, 0);
    tbl[3]  = v(0, 4'h0, 0, 1, 0, 4'h1, 0, 1, 0, 1);
    tbl[4]  = v(0, 4'h0, 0, 0, 1, 4'h0, 0, 1, 0, 1);
    tbl[5]  = v(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 1);
    tbl[6]  = v(1, 4'h1, 0, 0, 0, 4'h0, 2, 0, 0, 1);
    tbl[7]  = v(0, 4'h0, 1, 0, 0, 4'h0, 2, 1, 0, 1);
    tbl[8]  = v(0, 4'h0, 0, 1, 0, 4'h4, 2, 1, 0, 1);
    tbl[9]  = v(0, 4'h0, 0, 1, 0, 4'hB, 2, 1, 0, 0);
    tbl[10] = v(0, 4'h0, 0, 0, 1, 4'h0, 2, 1, 0, 0);
    tbl[11] = v(0, 4'h0, 0, 0, 0, 4'h0, 2, 0, 0, 0);
    tbl[12] = v(1, 4'h7, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    tbl[13] = v(1, 4'h2, 0, 0, 0, 4'h0, 3, 0, 0, 0);
    tbl[14] = v(1, 4'hF, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    tbl[15] = v(1, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 0);
    tbl[16] = v(0, 4'h0, 1, 0, 0, 4'h0, 1, 1, 0, 0);
    tbl[17] = v(0, 4'h0, 0, 1, 0, 4'h2, 1, 1, 0, 1);
    tbl[18] = v(1, 4'h2, 0, 1, 0, 4'h2, 1, 1, 1, 1);
    tbl[19] = v(0, 4'h0, 0, 1, 0, 4'h0, 1, 1, 0, 0);
    tbl[20] = v(0, 4'h0, 0, 0, 1, 4'h0, 1, 1, 0, 0);
    tbl[21] = v(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 0);
    tbl[22] = v(0, 4'h0, 1, 0, 0, 4'h0, 1, 1, 0, 0);
    tbl[23] = v(1, 4'h1, 0, 0, 0, 4'h0, 1, 0, 1, 0);
    tbl[24] = v(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 0);
    tbl[25] = v(0, 4'h0, 1, 0, 0, 4'h0, 1, 1, 0, 0);
    tbl[26] = v(0, 4'h0, 0, 1, 0, 4'h2, 1, 1, 0, 1);
    tbl[27] = v(0, 4'h0, 1, 1, 1, 4'h0, 1, 1, 0, 0);
    tbl[28] = v(0, 4'h0, 0, 1, 0, 4'h2, 1, 1, 0, 1);
    tbl[29] = v(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 1);
    #1;
    chk("rst_sel", sel_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sdo", s_data_out, 0);
    chk("rst_drop", ir_drop, 0);
    chk("rst_len_err", len_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    foreach (tbl[i]) step(tbl[i]);
    // channel 1 (LEN 32): short scan then exact scan
    step(v(1, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 1));
    step(v(0, 4'h0, 1, 0, 0, 4'h0, 1, 1, 0, 1));
    repeat (31) step(v(0, 4'h0, 0, 1, 0, 4'h0, 1, 1, 0, 0));
    step(v(0, 4'h0, 0, 0, 1, 4'h0, 1, 1, 0, 0, 1, EXP_LE));
    step(v(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 0, 1, EXP_LE));
    step(v(0, 4'h0, 1, 0, 0, 4'h0, 1, 1, 0, 0, 1, 0));
    repeat (32) step(v(0, 4'h0, 0, 1, 0, 4'h0, 1, 1, 0, 0));
    step(v(0, 4'h0, 0, 0, 1, 4'h0, 1, 1, 0, 0, 1, 0));
    step(v(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 0, 1, 0));
    // reset in the middle of a channel-2 shift
    step(v(1, 4'h1, 0, 0, 0, 4'h0, 2, 0, 0, 0));
    step(v(0, 4'h0, 1, 0, 0, 4'h0, 2, 1, 0, 0));
    step(v(0, 4'h0, 0, 1, 0, 4'h4, 2, 1, 0, 1));
    step(v(0, 4'h0, 0, 1, 0, 4'h4, 2, 1, 0, 1));
    @(negedge clk);
    shift_dr = 1'b0; update_dr = 1'b1; rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sdo", s_data_out, 0);
    chk("mid_rst_sel", sel_out, 0);
    chk("mid_rst_update_dr_out", update_dr_out, 0);
    @(negedge clk);
    rst = 1'b0; update_dr = 1'b0; cur_sel = 2'd0;
    step(v(0, 4'h0, 0, 0, 0, 4'h4, 0, 0, 0, 0));
    step(v(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0));
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jtag_dr_select.md
JTAG_DR_SELECT -- requirements
Module: jtag_dr_select

Interface
REQ-001 Parameter N_CH, default 4: number of data-register channels; channel 0 SHALL be BYPASS.
REQ-002 Parameter IR_W, default 4: instruction-register width.
REQ-003 Parameter OPC, default {4'h2,4'h1,4'h0,4'hF} (N_CH*IR_W bits, channel i in slice i): opcode selecting channel i.
REQ-004 Parameter LEN, default {16'd32,16'd32,16'd32,16'd1} (N_CH*16 bits): expected shift length of channel i.
REQ-005 Derived CH_W = max(1, clog2(N_CH)).
REQ-006 clk  input  1  TCK-domain clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 ir_value  input  IR_W  current instruction register contents.
REQ-009 update_ir  input  1  Update-IR strobe, one cycle.
REQ-010 capture_dr / shift_dr / update_dr  input  1 each  TAP DR-state strobes, level-valid per cycle.
REQ-011 s_data_in  input  N_CH  serial output bit of each DR channel.
REQ-012 s_data_out  output  1  registered serial data toward TDO.
REQ-013 capture_dr_out / shift_dr_out / update_dr_out  output  N_CH each  per-channel strobes, at most one bit high.
REQ-014 sel_out  output  CH_W  currently selected channel.
REQ-015 busy  output  1  high while a DR scan is in progress.
REQ-016 ir_drop  output  1  one-cycle pulse: update_ir ignored.
REQ-017 len_err  output  1  sticky shift-length mismatch (only with DR_SHIFT_COUNT_EN).

Function
REQ-018 On update_ir while busy=0, sel SHALL load, next cycle, the lowest index i with ir_value==OPC[i]; no match SHALL select 0.
REQ-019 update_ir while busy=1 SHALL leave sel unchanged and pulse ir_drop high the following cycle.
REQ-020 FSM states IDLE, CAP, SHIFT, UPD: IDLE->CAP on capture_dr; CAP->SHIFT on shift_dr, else CAP->IDLE; SHIFT holds while shift_dr; SHIFT->UPD on update_dr; SHIFT->IDLE when shift_dr, update_dr both low; UPD->IDLE unconditionally.
REQ-021 capture_dr in SHIFT or UPD SHALL go to CAP (rescan); simultaneous strobes priority capture_dr > update_dr > shift_dr.
REQ-022 busy SHALL be high in CAP, SHIFT, UPD.
REQ-023 Strobe outputs SHALL be combinational: bit sel of each *_out equals the matching input, all other bits 0.
REQ-024 s_data_out SHALL register s_data_in[sel] on every cycle with shift_dr high, holding otherwise (one-cycle latency).
REQ-025 sel_out SHALL equal the sel register.

Reset
REQ-026 rst high SHALL immediately force sel=0, state IDLE, s_data_out=0, ir_drop=0, len_err=0, shift counter 0, regardless of clk.
REQ-027 Reset mid-scan SHALL abort the scan; no update strobe SHALL be generated for it.

Configuration
REQ-028 Macro DR_SHIFT_COUNT_EN defined: 16-bit saturating counter cleared in CAP, incremented per SHIFT cycle with shift_dr; on entering UPD, count!=LEN[sel] SHALL set len_err, cleared on next capture_dr.
REQ-029 Macro undefined: counter and compare logic absent, len_err tied 0, LEN ignored.

Verification
REQ-030 Reset release, no IR update, capture/shift 1/update -> sel_out=0, only bit 0 of strobes toggles, s_data_out follows s_data_in[0] one cycle late.
REQ-031 update_ir with ir_value=4'h1 while IDLE -> sel_out=2 next cycle; shift_dr high -> shift_dr_out=4'b0100.
REQ-032 update_ir with ir_value=4'h7 (no match) -> sel_out=0.
REQ-033 update_ir during SHIFT -> sel_out unchanged, ir_drop pulse one cycle, scan completes on old channel.
REQ-034 DR_SHIFT_COUNT_EN, channel 1 (LEN 32), 31 shift cycles then update_dr -> len_err=1; next capture_dr -> len_err=0; 32 cycles -> len_err stays 0.
REQ-035 rst asserted mid-SHIFT -> busy=0, s_data_out=0, sel_out=0 before next clk edge; no update_dr_out pulse.
